// File: rtl/sgd_x_writeback_multi.sv
// -----------------------------------------------------------------------------
// sgd_x_writeback_multi
//
// Model write-back engine. At the end of each epoch it reads the updated model
// x out of the per-engine bank memories one row at a time. Each row is streamed
// to host memory as DATA_W-bit beats. The epoch is split into write commands of
// at most MAX_BURST_BYTES. Epoch e is written to addr_model + e*epoch_bytes.
//
// Ports
//   clk, rst_n             clock; synchronous active-low reset
//   started                job active; low aborts, clears epoch_cnt, drops strobes
//   addr_model             host base byte address
//   dimension              number of model features
//   num_epochs             epochs in the job
//   wr_en                  write back the current epoch (sampled in IDLE only)
//   wr_done                one-cycle pulse when an epoch write-back completes
//   epoch_cnt              epochs written so far
//   x_mem_rd_addr          row address broadcast to all banks
//   x_mem_rd_data          row read data; engine i at [i*BANK_BITS*32 +: BANK_BITS*32]
//   cmd_start              one-cycle write-command strobe
//   cmd_addr, cmd_length   command byte address / length in bytes
//   data_out(_valid)       beat stream
//   data_out_almost_full   downstream backpressure (one beat of slack needed)
//
// All outputs are registers.
// -----------------------------------------------------------------------------
module sgd_x_writeback_multi #(
   parameter int ENGINE_NUM      = 8,
   parameter int BANK_BITS       = 8,
   parameter int DATA_W          = 512,
   parameter int MAX_BURST_BYTES = 4096,
   parameter int MEM_LAT         = 2,
   parameter int ADDR_W          = 10
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                started,
   input  logic [63:0]                         addr_model,
   input  logic [31:0]                         dimension,
   input  logic [31:0]                         num_epochs,
   input  logic                                wr_en,
   output logic                                wr_done,
   output logic [31:0]                         epoch_cnt,
   output logic [ADDR_W-1:0]                   x_mem_rd_addr,
   input  logic [ENGINE_NUM*BANK_BITS*32-1:0]  x_mem_rd_data,
   output logic                                cmd_start,
   output logic [63:0]                         cmd_addr,
   output logic [31:0]                         cmd_length,
   output logic [DATA_W-1:0]                   data_out,
   output logic                                data_out_valid,
   input  logic                                data_out_almost_full
);

   // state    | meaning
   // ---------+--------------------------------------------------------------
   // IDLE     | waiting for wr_en; cmd_start registered on the way out
   // CMD      | cmd_start visible; load chunk row count, charge remaining
   // RD_WAIT  | row address held; down-counter covers the bank read latency
   // SEND     | one beat per cycle from the row register unless almost_full
   // DONE     | wr_done registered, epoch_cnt advanced
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CMD     = 3'd1,
      RD_WAIT = 3'd2,
      SEND    = 3'd3,
      DONE    = 3'd4
   } state_t;

   localparam int ROW_W   = ENGINE_NUM * BANK_BITS * 32;
   localparam int BEATS   = ROW_W / DATA_W;
   localparam int BEAT_CW = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int LAT_CW  = $clog2(MEM_LAT + 1);

   localparam logic [31:0]         FEATS_PER_ROW = 32'(ENGINE_NUM * BANK_BITS);
   localparam logic [31:0]         ROW_BYTES     = 32'(ROW_W / 8);
   localparam logic [63:0]         MAX_BURST     = 64'(MAX_BURST_BYTES);
   localparam logic [BEAT_CW-1:0]  LAST_BEAT     = BEAT_CW'(BEATS - 1);
   localparam logic [LAT_CW-1:0]   LAT_LOAD      = LAT_CW'(MEM_LAT);

   state_t                          state_q, state_d;
   logic [31:0]                     epoch_cnt_q, epoch_cnt_d;
   logic [31:0]                     row_q, row_d;
   logic [63:0]                     burst_addr_q, burst_addr_d;
   logic [63:0]                     remaining_q, remaining_d;
   logic [31:0]                     chunk_bytes_q, chunk_bytes_d;
   logic [31:0]                     chunk_rows_q, chunk_rows_d;
   logic [LAT_CW-1:0]               wait_cnt_q, wait_cnt_d;
   logic [BEAT_CW-1:0]              beat_q, beat_d;
   logic [BEATS-1:0][DATA_W-1:0]    row_reg_q, row_reg_d;
   logic [ADDR_W-1:0]               rd_addr_q, rd_addr_d;
   logic                            cmd_start_q, cmd_start_d;
   logic [DATA_W-1:0]               data_q, data_d;
   logic                            data_valid_q, data_valid_d;
   logic                            wr_done_q, wr_done_d;

   logic [31:0]                     rows;
   logic [63:0]                     epoch_bytes;
   logic [63:0]                     epoch_base;
   logic [31:0]                     row_inc;
   logic [63:0]                     remaining_after;

   // Command length is the smaller of what is left and the burst cap. Both are
   // whole rows, so the chunk always holds an integral number of rows.
   function automatic logic [31:0] clip_chunk(input logic [63:0] bytes);
      if (bytes > MAX_BURST) begin
         return MAX_BURST[31:0];
      end
      return bytes[31:0];
   endfunction

   // Ceiling division without widening: add one row when a remainder exists.
   assign rows        = (dimension / FEATS_PER_ROW) +
                        {31'd0, |(dimension % FEATS_PER_ROW)};
   assign epoch_bytes = {32'd0, rows} * {32'd0, ROW_BYTES};
   assign epoch_base  = addr_model + ({32'd0, epoch_cnt_q} * epoch_bytes);
   assign row_inc     = row_q + 32'd1;
   assign remaining_after = remaining_q;

   always_comb begin
      state_d       = state_q;
      epoch_cnt_d   = epoch_cnt_q;
      row_d         = row_q;
      burst_addr_d  = burst_addr_q;
      remaining_d   = remaining_q;
      chunk_bytes_d = chunk_bytes_q;
      chunk_rows_d  = chunk_rows_q;
      wait_cnt_d    = wait_cnt_q;
      beat_d        = beat_q;
      row_reg_d     = row_reg_q;
      rd_addr_d     = rd_addr_q;
      data_d        = data_q;
      cmd_start_d   = 1'b0;
      data_valid_d  = 1'b0;
      wr_done_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (started && wr_en && (epoch_cnt_q < num_epochs)) begin
               if (rows == 32'd0) begin
                  state_d = DONE;
               end else begin
                  row_d         = 32'd0;
                  burst_addr_d  = epoch_base;
                  remaining_d   = epoch_bytes;
                  chunk_bytes_d = clip_chunk(epoch_bytes);
                  cmd_start_d   = 1'b1;
                  state_d       = CMD;
               end
            end
         end

         CMD: begin
            chunk_rows_d = chunk_bytes_q / ROW_BYTES;
            remaining_d  = remaining_q - {32'd0, chunk_bytes_q};
            rd_addr_d    = row_q[ADDR_W-1:0];
            wait_cnt_d   = LAT_LOAD;
            state_d      = RD_WAIT;
         end

         RD_WAIT: begin
            if (wait_cnt_q == '0) begin
               row_reg_d = x_mem_rd_data;
               beat_d    = '0;
               state_d   = SEND;
            end else begin
               wait_cnt_d = wait_cnt_q - LAT_CW'(1);
            end
         end

         SEND: begin
            if (!data_out_almost_full) begin
               data_d       = row_reg_q[beat_q];
               data_valid_d = 1'b1;
               if (beat_q == LAST_BEAT) begin
                  row_d        = row_inc;
                  chunk_rows_d = chunk_rows_q - 32'd1;
                  if (chunk_rows_q != 32'd1) begin
                     rd_addr_d  = row_inc[ADDR_W-1:0];
                     wait_cnt_d = LAT_LOAD;
                     state_d    = RD_WAIT;
                  end else if (remaining_after != 64'd0) begin
                     // The last beat of this burst is registered in the same
                     // edge as the next strobe, so the new command can never
                     // appear ahead of it.
                     burst_addr_d  = burst_addr_q + {32'd0, chunk_bytes_q};
                     chunk_bytes_d = clip_chunk(remaining_q);
                     cmd_start_d   = 1'b1;
                     state_d       = CMD;
                  end else begin
                     state_d = DONE;
                  end
               end else begin
                  beat_d = beat_q + BEAT_CW'(1);
               end
            end
         end

         DONE: begin
            wr_done_d   = 1'b1;
            epoch_cnt_d = epoch_cnt_q + 32'd1;
            state_d     = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Abort wins over everything, including a pending wr_done.
      if (!started) begin
         state_d      = IDLE;
         epoch_cnt_d  = 32'd0;
         cmd_start_d  = 1'b0;
         data_valid_d = 1'b0;
         wr_done_d    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         epoch_cnt_q   <= 32'd0;
         row_q         <= 32'd0;
         burst_addr_q  <= 64'd0;
         remaining_q   <= 64'd0;
         chunk_bytes_q <= 32'd0;
         chunk_rows_q  <= 32'd0;
         wait_cnt_q    <= '0;
         beat_q        <= '0;
         row_reg_q     <= '0;
         rd_addr_q     <= '0;
         cmd_start_q   <= 1'b0;
         data_q        <= '0;
         data_valid_q  <= 1'b0;
         wr_done_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         epoch_cnt_q   <= epoch_cnt_d;
         row_q         <= row_d;
         burst_addr_q  <= burst_addr_d;
         remaining_q   <= remaining_d;
         chunk_bytes_q <= chunk_bytes_d;
         chunk_rows_q  <= chunk_rows_d;
         wait_cnt_q    <= wait_cnt_d;
         beat_q        <= beat_d;
         row_reg_q     <= row_reg_d;
         rd_addr_q     <= rd_addr_d;
         cmd_start_q   <= cmd_start_d;
         data_q        <= data_d;
         data_valid_q  <= data_valid_d;
         wr_done_q     <= wr_done_d;
      end
   end

   assign wr_done        = wr_done_q;
   assign epoch_cnt      = epoch_cnt_q;
   assign x_mem_rd_addr  = rd_addr_q;
   assign cmd_start      = cmd_start_q;
   assign cmd_addr       = burst_addr_q;
   assign cmd_length     = chunk_bytes_q;
   assign data_out       = data_q;
   assign data_out_valid = data_valid_q;

endmodule

// File: tb/tb_sgd_x_writeback_multi.sv
// -----------------------------------------------------------------------------
// Testbench for sgd_x_writeback_multi. The bank memory is a MEM_LAT-deep
// pipeline of the row address. Each 32-bit word carries {tag, row, word index},
// so the order of beats and the rows they come from can be recovered from the data.
// -----------------------------------------------------------------------------
module tb_sgd_x_writeback_multi;

   localparam int ENGINE_NUM      = 8;
   localparam int BANK_BITS       = 8;
   localparam int DATA_W          = 512;
   localparam int MAX_BURST_BYTES = 4096;
   localparam int MEM_LAT         = 2;
   localparam int ADDR_W          = 10;
   localparam int ROW_W           = ENGINE_NUM * BANK_BITS * 32;
   localparam int BEATS           = ROW_W / DATA_W;
   localparam int WORDS           = ENGINE_NUM * BANK_BITS;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 started = 1'b0;
   logic [63:0]          addr_model = 64'h1234;
   logic [31:0]          dimension = 32'd0;
   logic [31:0]          num_epochs = 32'd3;
   logic                 wr_en = 1'b0;
   logic                 wr_done;
   logic [31:0]          epoch_cnt;
   logic [ADDR_W-1:0]    x_mem_rd_addr;
   logic [ROW_W-1:0]     x_mem_rd_data;
   logic                 cmd_start;
   logic [63:0]          cmd_addr;
   logic [31:0]          cmd_length;
   logic [DATA_W-1:0]    data_out;
   logic                 data_out_valid;
   logic                 data_out_almost_full = 1'b0;

   logic [7:0]           tag = 8'h00;
   logic [ADDR_W-1:0]    mem_pipe [MEM_LAT];

   int checks = 0;
   int errors = 0;

   sgd_x_writeback_multi #(
      .ENGINE_NUM(ENGINE_NUM), .BANK_BITS(BANK_BITS), .DATA_W(DATA_W),
      .MAX_BURST_BYTES(MAX_BURST_BYTES), .MEM_LAT(MEM_LAT), .ADDR_W(ADDR_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .started(started), .addr_model(addr_model),
      .dimension(dimension), .num_epochs(num_epochs), .wr_en(wr_en),
      .wr_done(wr_done), .epoch_cnt(epoch_cnt), .x_mem_rd_addr(x_mem_rd_addr),
      .x_mem_rd_data(x_mem_rd_data), .cmd_start(cmd_start), .cmd_addr(cmd_addr),
      .cmd_length(cmd_length), .data_out(data_out), .data_out_valid(data_out_valid),
      .data_out_almost_full(data_out_almost_full)
   );

   always #5 clk = ~clk;

   function automatic logic [ROW_W-1:0] mk_row(input logic [ADDR_W-1:0] r, input logic [7:0] t);
      logic [ROW_W-1:0] v;
      v = '0;
      for (int j = 0; j < WORDS; j++) v[j*32 +: 32] = {t, 2'b00, r, j[11:0]};
      return v;
   endfunction

   function automatic logic [DATA_W-1:0] exp_beat(input int n, input logic [7:0] t);
      logic [ROW_W-1:0] r;
      r = mk_row(ADDR_W'(n / BEATS), t);
      return r[(n % BEATS)*DATA_W +: DATA_W];
   endfunction

   always @(posedge clk) begin
      mem_pipe[0] <= x_mem_rd_addr;
      for (int s = 1; s < MEM_LAT; s++) mem_pipe[s] <= mem_pipe[s-1];
   end
   assign x_mem_rd_data = mk_row(mem_pipe[MEM_LAT-1], tag);

   // Monitor: records strobes and scores every beat against the memory model.
   int cyc = 0, beat_n = 0, epoch_beats = -1, done_n = 0, done_cyc = -1;
   int last_beat_cyc = -1, first_beat_cyc = -1, wr_en_cyc = -1, sb_bad = 0;
   logic [63:0] cmd_addrs [$];
   logic [31:0] cmd_lens [$];
   int          cmd_cycs [$];
   int          cmd_beats [$];

   always @(negedge clk) begin
      if (wr_en) wr_en_cyc = cyc;
      if (data_out_valid) begin
         if (beat_n == 0) first_beat_cyc = cyc;
         if (data_out !== exp_beat(beat_n, tag)) sb_bad++;
         beat_n++;
         last_beat_cyc = cyc;
      end
      if (cmd_start) begin
         cmd_addrs.push_back(cmd_addr);
         cmd_lens.push_back(cmd_length);
         cmd_cycs.push_back(cyc);
         cmd_beats.push_back(beat_n);
      end
      if (wr_done) begin
         done_n++;
         done_cyc = cyc;
         epoch_beats = beat_n;
         beat_n = 0;
      end
      if (!started) beat_n = 0;
      cyc++;
   end

   task automatic restart_job(input logic [31:0] dim, input logic [7:0] t);
      @(posedge clk); #1;
      started = 1'b0; wr_en = 1'b0; data_out_almost_full = 1'b0;
      dimension = dim; tag = t;
      repeat (3) @(posedge clk);
      #1 started = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic pulse_wr_en();
      @(posedge clk); #1 wr_en = 1'b1;
      @(posedge clk); #1 wr_en = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit to);
      int d0;
      d0 = done_n;
      to = 1'b1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done_n != d0) begin to = 1'b0; break; end
      end
   endtask

   task automatic wait_beats(input int n, input int budget, output bit to);
      to = 1'b1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (beat_n >= n) begin to = 1'b0; break; end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; started = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if ({cmd_start, data_out_valid, wr_done} !== 3'b000) begin errors++; $display("FAIL reset_strobes: got %b expected 000", {cmd_start, data_out_valid, wr_done}); end
      checks++; if (epoch_cnt !== 32'd0) begin errors++; $display("FAIL reset_epoch_cnt: got %0d expected 0", epoch_cnt); end
      checks++; if ({x_mem_rd_addr, cmd_addr, cmd_length} !== '0) begin errors++; $display("FAIL reset_addr_len: got addr %h cmd %h len %0d expected 0", x_mem_rd_addr, cmd_addr, cmd_length); end
      checks++; if (data_out !== '0) begin errors++; $display("FAIL reset_data_out: got nonzero expected 0"); end
      @(posedge clk); #1 rst_n = 1'b1;
   endtask

   task automatic test_single_epoch();
      int c0, sb0, nc; bit to;
      restart_job(32'd256, 8'h21);
      c0 = cmd_addrs.size(); sb0 = sb_bad;
      pulse_wr_en();
      wait_done(500, to);
      nc = cmd_addrs.size() - c0;
      checks++; if (to) begin errors++; $display("FAIL single_timeout: no wr_done within 500 cycles"); end
      checks++; if (nc != 1) begin errors++; $display("FAIL single_cmd_count: got %0d expected 1", nc); end
      checks++; if ((nc > 0 ? cmd_addrs[c0] : 64'hFFFF) !== 64'h1234) begin errors++; $display("FAIL single_cmd_addr: got %h expected 1234", nc > 0 ? cmd_addrs[c0] : 64'hFFFF); end
      checks++; if ((nc > 0 ? cmd_lens[c0] : 32'd0) !== 32'd1024) begin errors++; $display("FAIL single_cmd_len: got %0d expected 1024", nc > 0 ? cmd_lens[c0] : 32'd0); end
      checks++; if ((nc > 0 ? cmd_cycs[c0] : -1) != wr_en_cyc + 1) begin errors++; $display("FAIL single_cmd_latency: got %0d expected %0d", nc > 0 ? cmd_cycs[c0] : -1, wr_en_cyc + 1); end
      checks++; if (first_beat_cyc != wr_en_cyc + 6) begin errors++; $display("FAIL single_first_beat: got cycle %0d expected %0d", first_beat_cyc, wr_en_cyc + 6); end
      checks++; if (epoch_beats != 16) begin errors++; $display("FAIL single_beats: got %0d expected 16", epoch_beats); end
      checks++; if (done_cyc != last_beat_cyc + 1) begin errors++; $display("FAIL single_done_timing: got cycle %0d expected %0d", done_cyc, last_beat_cyc + 1); end
      checks++; if (done_cyc != wr_en_cyc + 31) begin errors++; $display("FAIL single_row_cost: done at %0d expected %0d", done_cyc, wr_en_cyc + 31); end
      checks++; if (sb_bad != sb0) begin errors++; $display("FAIL single_data: got %0d bad beats expected 0", sb_bad - sb0); end
      @(negedge clk);
      checks++; if (epoch_cnt !== 32'd1) begin errors++; $display("FAIL single_epoch_cnt: got %0d expected 1", epoch_cnt); end
   endtask

   task automatic test_multi_burst();
      int c0, sb0, nc; bit to;
      restart_job(32'd2048, 8'h32);
      c0 = cmd_addrs.size(); sb0 = sb_bad;
      pulse_wr_en();
      wait_done(1000, to);
      nc = cmd_addrs.size() - c0;
      checks++; if (to) begin errors++; $display("FAIL multi_timeout: no wr_done within 1000 cycles"); end
      checks++; if (nc != 2) begin errors++; $display("FAIL multi_cmd_count: got %0d expected 2", nc); end
      checks++; if ((nc > 0 ? cmd_addrs[c0] : 64'hFFFF) !== 64'h1234 || (nc > 0 ? cmd_lens[c0] : 32'd0) !== 32'd4096) begin errors++; $display("FAIL multi_cmd0: got %h/%0d expected 1234/4096", nc > 0 ? cmd_addrs[c0] : 64'hFFFF, nc > 0 ? cmd_lens[c0] : 32'd0); end
      checks++; if ((nc > 1 ? cmd_addrs[c0+1] : 64'hFFFF) !== 64'h2234 || (nc > 1 ? cmd_lens[c0+1] : 32'd0) !== 32'd4096) begin errors++; $display("FAIL multi_cmd1: got %h/%0d expected 2234/4096", nc > 1 ? cmd_addrs[c0+1] : 64'hFFFF, nc > 1 ? cmd_lens[c0+1] : 32'd0); end
      checks++; if ((nc > 1 ? cmd_beats[c0+1] : -1) != 64) begin errors++; $display("FAIL multi_cmd1_order: beats out at second strobe %0d expected 64", nc > 1 ? cmd_beats[c0+1] : -1); end
      checks++; if (epoch_beats != 128) begin errors++; $display("FAIL multi_beats: got %0d expected 128", epoch_beats); end
      checks++; if (sb_bad != sb0) begin errors++; $display("FAIL multi_data: got %0d bad beats expected 0", sb_bad - sb0); end
   endtask

   task automatic test_three_epochs();
      logic [63:0] exp_a [3];
      int c0, c1, d1, nc; bit to;
      exp_a[0] = 64'h1234; exp_a[1] = 64'h1634; exp_a[2] = 64'h1A34;
      restart_job(32'd256, 8'h43);
      c0 = cmd_addrs.size();
      for (int e = 0; e < 3; e++) begin
         pulse_wr_en();
         wait_done(500, to);
         checks++; if (to) begin errors++; $display("FAIL epochs_timeout: epoch %0d no wr_done", e); end
      end
      nc = cmd_addrs.size() - c0;
      for (int e = 0; e < 3; e++) begin
         checks++; if ((nc > e ? cmd_addrs[c0+e] : 64'hFFFF) !== exp_a[e]) begin errors++; $display("FAIL epochs_addr%0d: got %h expected %h", e, nc > e ? cmd_addrs[c0+e] : 64'hFFFF, exp_a[e]); end
      end
      @(negedge clk);
      checks++; if (epoch_cnt !== 32'd3) begin errors++; $display("FAIL epochs_cnt: got %0d expected 3", epoch_cnt); end
      c1 = cmd_addrs.size(); d1 = done_n;
      pulse_wr_en();
      repeat (60) @(negedge clk);
      checks++; if (cmd_addrs.size() != c1) begin errors++; $display("FAIL epochs_extra_cmd: got %0d strobes expected 0", cmd_addrs.size() - c1); end
      checks++; if (done_n != d1) begin errors++; $display("FAIL epochs_extra_done: got %0d pulses expected 0", done_n - d1); end
   endtask

   task automatic test_partial_rows();
      int c0, c1, sb0, nc; bit to;
      restart_job(32'd65, 8'h54);
      c0 = cmd_addrs.size(); sb0 = sb_bad;
      pulse_wr_en();
      wait_done(500, to);
      nc = cmd_addrs.size() - c0;
      checks++; if (to) begin errors++; $display("FAIL partial_timeout: no wr_done within 500 cycles"); end
      checks++; if ((nc > 0 ? cmd_lens[c0] : 32'd0) !== 32'd512) begin errors++; $display("FAIL partial_len: got %0d expected 512", nc > 0 ? cmd_lens[c0] : 32'd0); end
      checks++; if (epoch_beats != 8) begin errors++; $display("FAIL partial_beats: got %0d expected 8", epoch_beats); end
      checks++; if (sb_bad != sb0) begin errors++; $display("FAIL partial_data: got %0d bad beats expected 0", sb_bad - sb0); end
      @(posedge clk); #1 dimension = 32'd0;
      c1 = cmd_addrs.size();
      pulse_wr_en();
      wait_done(50, to);
      checks++; if (to) begin errors++; $display("FAIL zero_dim_done: no wr_done within 50 cycles"); end
      checks++; if (cmd_addrs.size() != c1) begin errors++; $display("FAIL zero_dim_cmd: got %0d strobes expected 0", cmd_addrs.size() - c1); end
      @(negedge clk);
      checks++; if (epoch_cnt !== 32'd2) begin errors++; $display("FAIL zero_dim_epoch_cnt: got %0d expected 2", epoch_cnt); end
   endtask

   task automatic test_backpressure();
      int sb0, v; bit to;
      restart_job(32'd256, 8'h65);
      sb0 = sb_bad;
      pulse_wr_en();
      wait_beats(6, 200, to);
      checks++; if (to) begin errors++; $display("FAIL bp_start: 6 beats not seen within 200 cycles"); end
      @(posedge clk); #1 data_out_almost_full = 1'b1;
      @(negedge clk);
      v = 0;
      repeat (19) begin
         @(negedge clk);
         if (data_out_valid) v++;
      end
      @(posedge clk); #1 data_out_almost_full = 1'b0;
      checks++; if (v != 0) begin errors++; $display("FAIL bp_valid_low: got %0d beats while stalled expected 0", v); end
      wait_done(500, to);
      checks++; if (to) begin errors++; $display("FAIL bp_timeout: no wr_done within 500 cycles"); end
      checks++; if (epoch_beats != 16) begin errors++; $display("FAIL bp_beats: got %0d expected 16", epoch_beats); end
      checks++; if (sb_bad != sb0) begin errors++; $display("FAIL bp_data: got %0d bad beats expected 0", sb_bad - sb0); end
   endtask

   task automatic test_abort();
      int d0, c1, sb0, nc; bit to;
      restart_job(32'd256, 8'h76);
      pulse_wr_en();
      wait_done(500, to);
      checks++; if (to) begin errors++; $display("FAIL abort_epoch0: no wr_done within 500 cycles"); end
      pulse_wr_en();
      wait_beats(2, 200, to);
      checks++; if (to) begin errors++; $display("FAIL abort_send: epoch 1 beats not seen within 200 cycles"); end
      d0 = done_n;
      @(posedge clk); #1 started = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++; if ({cmd_start, data_out_valid, wr_done} !== 3'b000) begin errors++; $display("FAIL abort_strobes: got %b expected 000", {cmd_start, data_out_valid, wr_done}); end
      checks++; if (epoch_cnt !== 32'd0) begin errors++; $display("FAIL abort_epoch_cnt: got %0d expected 0", epoch_cnt); end
      repeat (40) @(negedge clk);
      checks++; if (done_n != d0) begin errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", done_n - d0); end
      @(posedge clk); #1 started = 1'b1;
      c1 = cmd_addrs.size(); sb0 = sb_bad;
      pulse_wr_en();
      wait_done(500, to);
      nc = cmd_addrs.size() - c1;
      checks++; if (to) begin errors++; $display("FAIL abort_restart_timeout: no wr_done within 500 cycles"); end
      checks++; if ((nc > 0 ? cmd_addrs[c1] : 64'hFFFF) !== 64'h1234) begin errors++; $display("FAIL abort_restart_addr: got %h expected 1234", nc > 0 ? cmd_addrs[c1] : 64'hFFFF); end
      checks++; if (epoch_beats != 16 || sb_bad != sb0) begin errors++; $display("FAIL abort_restart_data: got %0d beats %0d bad expected 16 and 0", epoch_beats, sb_bad - sb0); end
      @(negedge clk);
      checks++; if (epoch_cnt !== 32'd1) begin errors++; $display("FAIL abort_restart_cnt: got %0d expected 1", epoch_cnt); end
   endtask

   initial begin
      test_reset();
      test_single_epoch();
      test_multi_burst();
      test_three_epochs();
      test_partial_rows();
      test_backpressure();
      test_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish by 1000000 ns");
      $fatal(1);
   end

endmodule
